// File: rtl/mux_pkg.sv
// Shared helpers for the scan_mux selector family: select-width derivation
// and the lane slicing rule used for both the IN and Y buses.
package mux_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // A select bus is never narrower than one bit, even for a single-entry range.
    function automatic int sel_width(input int entries);
        return (clog2(entries) < 1) ? 1 : clog2(entries);
    endfunction

    // LSB of lane (grp, idx) in a bus of grp-major lanes, `lanes` per group.
    function automatic int lane_lsb(input int grp, input int idx, input int lanes, input int width);
        return (grp * lanes + idx) * width;
    endfunction

endpackage

// File: rtl/scan_counter.sv
// Auto-scan index generator: a DIV-clock prescaler stepping an index through
// 0..N-1, with a registered pulse on every index advance.
module scan_counter
    import mux_pkg::*;
#(
    parameter int N = 4,
    parameter int DIV = 4,
    localparam int SW = sel_width(N)
) (
    input  logic          CLK,
    input  logic          nCLR,
    input  logic          AUTO,
    input  logic          HOLD,
    output logic [SW-1:0] IDX,
    output logic          STEP
);

    localparam int PW = sel_width(DIV);

    logic [PW-1:0] prescale;

    // Leaving auto mode parks the scan at index 0 with a fresh prescale period,
    // so re-entry always gives index 0 a full DIV cycles.
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            prescale <= '0;
            IDX      <= '0;
            STEP     <= 1'b0;
        end else if (!AUTO) begin
            prescale <= '0;
            IDX      <= '0;
            STEP     <= 1'b0;
        end else if (HOLD) begin
            STEP     <= 1'b0;
        end else if (prescale == PW'(DIV - 1)) begin
            prescale <= '0;
            IDX      <= (IDX == SW'(N - 1)) ? '0 : IDX + 1'b1;
            STEP     <= 1'b1;
        end else begin
            prescale <= prescale + 1'b1;
            STEP     <= 1'b0;
        end
    end

endmodule

// File: rtl/scan_mux.sv
// G groups of registered N:1 W-bit selectors with active-low strobes, driven by
// a manual address or the internal auto-scan index; the select used is exported.
module scan_mux
    import mux_pkg::*;
#(
    parameter int W = 1,
    parameter int N = 4,
    parameter int G = 2,
    parameter int DIV = 4,
    localparam int SW = sel_width(N)
) (
    input  logic             CLK,
    input  logic             nCLR,
    input  logic [G-1:0]     nS,
    input  logic [G*N*W-1:0] IN,
    input  logic [SW-1:0]    A,
    input  logic             AUTO,
    input  logic             HOLD,
    output logic [G*W-1:0]   Y,
    output logic [SW-1:0]    SEL,
    output logic             STEP
);

    logic [SW-1:0]  scan_idx;
    logic [SW-1:0]  sel_p0;
    logic [G*W-1:0] y_p0;

    scan_counter #(
        .N   (N),
        .DIV (DIV)
    ) u_scan (
        .CLK  (CLK),
        .nCLR (nCLR),
        .AUTO (AUTO),
        .HOLD (HOLD),
        .IDX  (scan_idx),
        .STEP (STEP)
    );

    // Stage p0: select resolution and lane gathering.
    // An address beyond N-1 matches no lane, so every group reads 0.
    always_comb begin
        sel_p0 = AUTO ? scan_idx : A;
        y_p0   = '0;
        for (int g = 0; g < G; g++) begin
            for (int i = 0; i < N; i++) begin
                if (!nS[g] && sel_p0 == SW'(i)) begin
                    y_p0[lane_lsb(g, 0, 1, W) +: W] = IN[lane_lsb(g, i, N, W) +: W];
                end
            end
        end
    end

    // Stage p1: output registers; SEL is registered with Y so the pair stays aligned.
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            Y   <= '0;
            SEL <= '0;
        end else begin
            Y   <= y_p0;
            SEL <= sel_p0;
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// Randomized and directed bench for scan_mux across three parameter sets,
// checked against an elapsed-count behavioural model.
module tb_scan_mux;

    logic CLK;
    logic nCLR;

    // dut_a: W=1 N=4 G=2 DIV=4
    logic [7:0] in_a;
    logic [1:0] ns_a;
    logic [1:0] a_a;
    logic       auto_a, hold_a;
    logic [1:0] y_a;
    logic [1:0] sel_a;
    logic       step_a;

    // dut_b: W=4 N=3 G=3 DIV=2
    logic [35:0] in_b;
    logic [2:0]  ns_b;
    logic [1:0]  a_b;
    logic        auto_b, hold_b;
    logic [11:0] y_b;
    logic [1:0]  sel_b;
    logic        step_b;

    // dut_c: W=2 N=4 G=1 DIV=1
    logic [7:0] in_c;
    logic [0:0] ns_c;
    logic [1:0] a_c;
    logic       auto_c, hold_c;
    logic [1:0] y_c;
    logic [1:0] sel_c;
    logic       step_c;

    int n_cmp;
    int n_err;
    int ta, tb_t, tc;

    scan_mux #(.W(1), .N(4), .G(2), .DIV(4)) dut_a (
        .CLK(CLK), .nCLR(nCLR), .nS(ns_a), .IN(in_a), .A(a_a),
        .AUTO(auto_a), .HOLD(hold_a), .Y(y_a), .SEL(sel_a), .STEP(step_a)
    );

    scan_mux #(.W(4), .N(3), .G(3), .DIV(2)) dut_b (
        .CLK(CLK), .nCLR(nCLR), .nS(ns_b), .IN(in_b), .A(a_b),
        .AUTO(auto_b), .HOLD(hold_b), .Y(y_b), .SEL(sel_b), .STEP(step_b)
    );

    scan_mux #(.W(2), .N(4), .G(1), .DIV(1)) dut_c (
        .CLK(CLK), .nCLR(nCLR), .nS(ns_c), .IN(in_c), .A(a_c),
        .AUTO(auto_c), .HOLD(hold_c), .Y(y_c), .SEL(sel_c), .STEP(step_c)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs from the lane layout rule: group g input i at bits (g*n+i)*w.
    function automatic logic [63:0] ref_y(input logic [63:0] din, input logic [7:0] ns,
                                          input int sel, input int n, input int g, input int w);
        logic [63:0] r;
        r = '0;
        for (int gi = 0; gi < g; gi++) begin
            if (!ns[gi] && sel < n) begin
                for (int b = 0; b < w; b++) begin
                    r[gi*w + b] = din[(gi*n + sel)*w + b];
                end
            end
        end
        return r;
    endfunction

    // t counts non-held auto edges since auto entry: index = (t/div)%n.
    task automatic model_edge(input logic au, input logic ho, input int div,
                              inout int t, output logic st);
        if (!au) begin
            t  = 0;
            st = 1'b0;
        end else if (ho) begin
            st = 1'b0;
        end else begin
            t  = t + 1;
            st = (t % div == 0);
        end
    endtask

    task automatic cycle();
        int sa, sb, sc;
        logic [63:0] ya, yb, yc;
        logic pa, pb, pc;
        sa = auto_a ? (ta / 4) % 4 : int'(a_a);
        sb = auto_b ? (tb_t / 2) % 3 : int'(a_b);
        sc = auto_c ? tc % 4 : int'(a_c);
        ya = ref_y({56'b0, in_a}, {6'b0, ns_a}, sa, 4, 2, 1);
        yb = ref_y({28'b0, in_b}, {5'b0, ns_b}, sb, 3, 3, 4);
        yc = ref_y({56'b0, in_c}, {7'b0, ns_c}, sc, 4, 1, 2);
        model_edge(auto_a, hold_a, 4, ta, pa);
        model_edge(auto_b, hold_b, 2, tb_t, pb);
        model_edge(auto_c, hold_c, 1, tc, pc);
        @(posedge CLK);
        #1;
        chk("y_a", 64'(y_a), ya);
        chk("sel_a", 64'(sel_a), 64'(sa));
        chk("step_a", 64'(step_a), 64'(pa));
        chk("y_b", 64'(y_b), yb);
        chk("sel_b", 64'(sel_b), 64'(sb));
        chk("step_b", 64'(step_b), 64'(pb));
        chk("y_c", 64'(y_c), yc);
        chk("sel_c", 64'(sel_c), 64'(sc));
        chk("step_c", 64'(step_c), 64'(pc));
    endtask

    task automatic jiggle_others();
        in_b = 36'({$urandom, $urandom});
        ns_b = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
        a_b  = 2'($urandom);
        in_c = 8'($urandom);
        ns_c = ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_y_a"}, 64'(y_a), 64'd0);
        chk({tag, "_sel_a"}, 64'(sel_a), 64'd0);
        chk({tag, "_step_a"}, 64'(step_a), 64'd0);
        chk({tag, "_y_b"}, 64'(y_b), 64'd0);
        chk({tag, "_y_c"}, 64'(y_c), 64'd0);
        chk({tag, "_step_c"}, 64'(step_c), 64'd0);
    endtask

    initial begin
        int guard;
        n_cmp = 0; n_err = 0;
        ta = 0; tb_t = 0; tc = 0;
        nCLR = 1'b0;
        in_a = '0; ns_a = '0; a_a = '0; auto_a = 1'b0; hold_a = 1'b0;
        in_b = '0; ns_b = '0; a_b = '0; auto_b = 1'b0; hold_b = 1'b0;
        in_c = '0; ns_c = '0; a_c = '0; auto_c = 1'b1; hold_c = 1'b0;

        #12;
        check_all_zero("reset");
        nCLR = 1'b1;

        // Manual mode on the reference pattern, then strobes.
        in_a = 8'b1010_0110;
        for (int i = 0; i < 4; i++) begin
            a_a = 2'(i);
            jiggle_others();
            cycle();
        end
        a_a = 2'd1; ns_a = 2'b10; jiggle_others(); cycle();
        ns_a = 2'b11; jiggle_others(); cycle();
        ns_a = 2'b00;

        // Non-power-of-two N with out-of-range manual address.
        a_b = 2'd3; ns_b = 3'b000; in_b = 36'hF_FFFF_FFFF;
        cycle();

        // Auto scan through a full wrap.
        auto_a = 1'b1;
        for (int i = 0; i < 18; i++) begin
            in_a = 8'($urandom);
            jiggle_others();
            cycle();
        end

        // Hold at index 2 for 10 cycles, then release.
        guard = 0;
        while ((ta / 4) % 4 != 2 && guard < 40) begin
            jiggle_others();
            cycle();
            guard++;
        end
        chk("reach_idx2", 64'((ta / 4) % 4), 64'd2);
        hold_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_a = 8'($urandom);
            jiggle_others();
            cycle();
        end
        hold_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            jiggle_others();
            cycle();
        end

        // Auto 1->0->1 restarts at index 0.
        auto_a = 1'b0; a_a = 2'd3; cycle();
        auto_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            jiggle_others();
            cycle();
        end

        // Asynchronous reset mid-run with nonzero outputs.
        auto_a = 1'b0; a_a = 2'd1; in_a = 8'hFF; ns_a = 2'b00; auto_c = 1'b1;
        cycle();
        #2;
        nCLR = 1'b0;
        #1;
        check_all_zero("async_clr");
        ta = 0; tb_t = 0; tc = 0;
        repeat (2) @(posedge CLK);
        #1;
        check_all_zero("clr_held");
        #3;
        nCLR = 1'b1;
        auto_a = 1'b1; hold_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            jiggle_others();
            cycle();
        end

        // Randomized mix on all three instances.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 11) == 0) auto_a = ~auto_a;
            if ($urandom_range(0, 9) == 0) auto_b = ~auto_b;
            if ($urandom_range(0, 15) == 0) auto_c = ~auto_c;
            hold_a = ($urandom_range(0, 7) == 0);
            hold_b = ($urandom_range(0, 7) == 0);
            hold_c = ($urandom_range(0, 7) == 0);
            a_a  = 2'($urandom);
            a_c  = 2'($urandom);
            in_a = 8'($urandom);
            ns_a = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            jiggle_others();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
